// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth sequential multiplier: drives an external encoder, accumulates PPs.
// Optional BOOTH_ACC_EARLY_EXIT_EN: leave RUN once no nonzero windows remain.
module booth_pp_accumulator #(
  parameter int N  = 1024,
  parameter int CW = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic           enc_x_low,
  output logic           enc_x,
  output logic           enc_x_high,
  output logic [N-1:0]   enc_y,
  input  logic [N:0]     enc_pp,
  input  logic           enc_sign,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p
);

  localparam int AW = 2*N + 2;
  localparam int XW = N + 3;
  localparam logic [CW-1:0] LAST = CW'(N/2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] xs_q, xs_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  y_q, y_d;

  logic [2:0]    win;
  logic [AW-1:0] pp_ext;
  logic [AW-1:0] term;
  logic [AW-1:0] term_sh;
  logic [XW-1:0] xs_shr;
  logic          unused_acc_top;

  assign win    = xs_q[2:0];
  assign xs_shr = xs_q >> 2;
  assign pp_ext = {{(N+1){enc_sign}}, enc_pp};

  // Window 111 is digit -0; the encoder output for it is ignored.
  always_comb begin
    term = pp_ext + AW'(enc_sign);
    if (win == 3'b111) term = '0;
    term_sh = term << {cnt_q, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = in_y;
          xs_d    = {2'b00, in_x, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + term_sh;
        xs_d  = xs_shr;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
`ifdef BOOTH_ACC_EARLY_EXIT_EN
        if (xs_shr == '0) state_d = DONE;
`else
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_p      = acc_q[2*N-1:0];
  assign enc_y      = y_q;
  assign enc_x_low  = (state_q == RUN) & win[0];
  assign enc_x      = (state_q == RUN) & win[1];
  assign enc_x_high = (state_q == RUN) & win[2];

  // Top two accumulator bits are guard bits, zero for valid operands.
  assign unused_acc_top = ^acc_q[AW-1:2*N];

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized bench for booth_pp_accumulator with a behavioural Booth encoder.
// Reference: plain x*y product, window list from the extended multiplier.
module tb_booth_pp_accumulator;

  localparam int N  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_x;
  logic [N-1:0]   in_y;
  logic           enc_x_low;
  logic           enc_x;
  logic           enc_x_high;
  logic [N-1:0]   enc_y;
  logic [N:0]     enc_pp;
  logic           enc_sign;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_p;

  logic [N:0]     junk_pp;
  logic           junk_s;
  int             dig;
  logic [N:0]     mag;

  int n_chk = 0;
  int n_fail = 0;

  booth_pp_accumulator #(.N(N), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_y(in_y),
    .enc_x_low(enc_x_low),
    .enc_x(enc_x),
    .enc_x_high(enc_x_high),
    .enc_y(enc_y),
    .enc_pp(enc_pp),
    .enc_sign(enc_sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p(out_p)
  );

  always #5 clk = ~clk;

  // Booth encoder: digit = x + x_low - 2*x_high; garbage for code 111.
  always_comb begin
    dig = int'(enc_x) + int'(enc_x_low) - 2 * int'(enc_x_high);
    mag = (N+1)'((dig < 0 ? -dig : dig) * int'(enc_y));
    enc_pp = mag;
    enc_sign = 1'b0;
    if ({enc_x_high, enc_x, enc_x_low} == 3'b111) begin
      enc_pp = junk_pp;
      enc_sign = junk_s;
    end else if (dig < 0) begin
      enc_pp = ~mag;
      enc_sign = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_runs(input logic [N-1:0] x);
    logic [N+2:0] xe;
    int k;
    xe = {2'b00, x, 1'b0};
    k = N/2 + 1;
`ifdef BOOTH_ACC_EARLY_EXIT_EN
    k = 1;
    while (k < N/2 + 1 && (xe >> (2*k)) != 0) k++;
`else
`endif
    return k;
  endfunction

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                        input int hold);
    logic [N+2:0]   xe;
    logic [2*N-1:0] ep;
    int cyc;
    int wi;
    xe = {2'b00, x, 1'b0};
    ep = (2*N)'(x) * (2*N)'(y);
    junk_pp = (N+1)'($urandom);
    junk_s = 1'(($urandom));
    cyc = 0;
    wi = 0;
    @(posedge clk); #1;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      in_valid = 1'b0;
      if (!out_valid) begin
        chk("in_ready_run", in_ready, 0);
        if (wi <= N/2)
          chk("win", {enc_x_high, enc_x, enc_x_low}, xe[2*wi +: 3]);
        else
          chk("win_count", wi, N/2);
        wi++;
      end
    end
    chk("out_valid", out_valid, 1);
    chk("latency", cyc, exp_runs(x) + 1);
    chk("out_p", out_p, ep);
    in_valid = 1'b1;
    in_x = ~x;
    in_y = ~y;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_p", out_p, ep);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("enc_y_hold", enc_y, y);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    out_ready = 1'b0;
    junk_pp = '0;
    junk_s = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_enc_y", enc_y, 0);
    chk("rst_enc_x", {enc_x_high, enc_x, enc_x_low}, 0);
    rst_n = 1'b1;

    run_op(8'h00, 8'h00, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h03, 8'h05, 0);
    run_op(8'h0E, 8'hAB, 0);
    run_op(8'h07, 8'h09, 10);

    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x = 8'hFF;
    in_y = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_p", out_p, 0);
    chk("mrst_enc_y", enc_y, 0);
    chk("mrst_enc_x", {enc_x_high, enc_x, enc_x_low}, 0);
    #3;
    rst_n = 1'b1;
    run_op(8'h0C, 8'h0C, 0);

    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] rx;
      logic [N-1:0] ry;
      rx = N'($urandom);
      ry = N'($urandom);
      if (i % 7 == 0) rx = 8'hFF;
      if (i % 5 == 0) ry = 8'hFF;
      if (i % 11 == 0) rx = N'($urandom_range(0, 3));
      run_op(rx, ry, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
